bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//   Sequential packed-BCD to binary converter using reverse double-dabble.
//   Each cycle: shift right 1, then subtract 3 from every BCD digit >= 8.
//   Inverse of the binary->BCD path. Used where keypad/display-side BCD
//   values must be returned to binary for arithmetic.
// PARAMETERS
//   DIGITS  4   number of packed BCD digits on bcd_in
//   WIDTH   14  binary result width; must be >= ceil(log2(10**DIGITS))
//               (4 digits -> 14). Also the iteration count.
// PORTS
//   clk      in   1          system clock, rising edge
//   reset    in   1          asynchronous, active-high reset
//   start    in   1          request conversion of bcd_in (sampled in IDLE)
//   bcd_in   in   4*DIGITS   packed BCD, digit 0 in [3:0]
//   busy     out  1          conversion in progress
//   done     out  1          one-cycle pulse: result valid
//   result   out  WIDTH      binary value, held until next done
//   err      out  1          invalid-digit flag; see CONFIGURATION
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, err=0, result=0; shift reg and count 0.
//   Reset is async; asserting mid-conversion aborts it. No done follows.
//   States:
//     IDLE  -> SHIFT when start=1 at edge k. Load bcd_in into the upper
//              4*DIGITS bits of a (4*DIGITS+WIDTH)-bit reg; lower bits 0.
//              Count=0. busy=1 from edge k.
//     SHIFT -> at each edge: reg = reg>>1, then per digit d>=8 -> d-3
//              (4-bit, no borrow between digits). Count++.
//              After WIDTH iterations (edge k+WIDTH): result = low WIDTH bits,
//              done=1, busy=0, state=IDLE.
//   Latency: done high in the cycle after edge k+WIDTH (WIDTH clocks after
//     the start edge). Throughput: one conversion per WIDTH+1 clocks.
//   start while busy=1: ignored; bcd_in is not re-sampled.
//   start=1 during the done cycle: accepted (state already IDLE).
//     done drops, busy rises at the same edge.
//   bcd_in need only be stable at the start edge.
//   done is a single-cycle pulse even if start is held high.
//   result changes only at the done edge.
//   Arithmetic: digit correction is an unsigned 4-bit subtract applied only
//     when d>=8; d<8 passes unchanged. No other carries.
// CONFIGURATION
//   `BCD_CHECK_EN defined:
//     At the start edge, any digit > 9 latches an invalid flag.
//     The conversion still runs the full WIDTH cycles (latency unchanged).
//     At the done edge: err=1 and result=0 if the flag is set.
//     Otherwise err=0 and the normal result is loaded.
//     err is held with result. It clears at reset or at the next done.
//   `BCD_CHECK_EN undefined:
//     err is tied 0 and no check logic is built.
//     Invalid digits run through the same algorithm. result is unspecified.
//     Benches must not check result for that case.
// TESTING
//   1. bcd_in=16'h1234, start 1 clk -> done 14 clks later, result=14'd1234,
//      busy high exactly 14 clks.
//   2. bcd_in=16'h9999 -> result=14'd9999 (14'h270F).
//      bcd_in=16'h0000 -> result=0.
//   3. start held high, bcd_in=16'h0042 then 16'h0100:
//      first done result=42, then back-to-back start accepted in the done cycle,
//      next done result=100. Each done is 1 clk wide.
//   4. start pulsed again mid-conversion with bcd_in=16'h5555 ->
//      ignored; result is still the first value, 1 done only.
//   5. reset asserted 5 clks into a conversion -> busy/done/result/err go 0
//      immediately (async). No done afterwards. Next start converts normally.
//   6. (BCD_CHECK_EN) bcd_in=16'h12A4 -> done after 14 clks, err=1, result=0.
//      Then 16'h0007 -> err=0, result=7.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   On each iteration the working register is shifted right by one bit.
//   Every BCD digit in the upper field that is now >= 8 then has 3
//   subtracted from it. After WIDTH iterations the low WIDTH bits hold
//   the binary value.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   start   in   request conversion of bcd_in (sampled only in IDLE)
//   bcd_in  in   packed BCD, digit 0 in [3:0]
//   busy    out  conversion in progress
//   done    out  one-cycle pulse, result valid
//   result  out  binary value, held until the next done
//   err     out  invalid-digit flag (only built with BCD_CHECK_EN)
//
// Build option
//   BCD_CHECK_EN : when defined, any digit > 9 at the start edge makes the
//                  conversion finish with err=1 and result=0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; done pulses here for one cycle after a run
// SHIFT | one shift/correct iteration per clock, WIDTH iterations total
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                err
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sr_q, sr_d;
    logic [SW-1:0]    step;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

`ifdef BCD_CHECK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;
    logic bad_in;

    always_comb begin
        bad_in = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end
`endif

    // One iteration: shift right, then fix up each BCD digit independently.
    // Digits live above the low WIDTH result bits; no borrow between digits.
    always_comb begin
        step = sr_q >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (step[WIDTH+4*d +: 4] >= 4'd8) begin
                step[WIDTH+4*d +: 4] = step[WIDTH+4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
`ifdef BCD_CHECK_EN
        bad_d    = bad_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {bcd_in, {WIDTH{1'b0}}};
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef BCD_CHECK_EN
                    bad_d   = bad_in;
`endif
                end
            end
            SHIFT: begin
                sr_d  = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef BCD_CHECK_EN
                    result_d = bad_q ? '0 : step[WIDTH-1:0];
                    err_d    = bad_q;
`else
                    result_d = step[WIDTH-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

`ifdef BCD_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy   = (state_q == SHIFT);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] result;
    logic        err;

    bcd_to_bin #(.DIGITS(4), .WIDTH(14)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] exp;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bcd_val(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Output monitor: every done pops one expected record.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_cnt++;
            chk("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got result %0d expected no done", result);
            end else begin
                e = sb.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("err", int'(err), int'(e.err));
            end
        end
        prev_done = reset ? 1'b0 : done;
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic run_conv(input logic [15:0] b, input logic [13:0] exp_res, input logic exp_err);
        int lat;
        int nb;
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        sb.push_back('{exp_res, exp_err});
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
        lat = 1;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 15);
        chk("busy_cycles", nb, 14);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int dc;
        logic [15:0] rb;

        vecs[0] = '{16'h1234, 14'd1234};
        vecs[1] = '{16'h9999, 14'd9999};
        vecs[2] = '{16'h0000, 14'd0};
        vecs[3] = '{16'h0001, 14'd1};
        vecs[4] = '{16'h0010, 14'd10};
        vecs[5] = '{16'h8765, 14'd8765};
        vecs[6] = '{16'h0999, 14'd999};
        vecs[7] = '{16'h5008, 14'd5008};
        for (int i = 8; i < 10; i++) begin
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            vecs[i] = '{rb, 14'(bcd_val(rb))};
        end

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;

        // Table-driven conversions
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bcd, vecs[i].exp, 1'b0);
        end

        // start held high: back-to-back acceptance in the done cycle
        @(negedge clk);
        bcd_in = 16'h0042;
        start  = 1'b1;
        sb.push_back('{14'd42, 1'b0});
        wait_done(lat);
        chk("b2b_lat1", lat, 15);
        chk("b2b_busy_at_done", int'(busy), 0);
        bcd_in = 16'h0100;
        sb.push_back('{14'd100, 1'b0});
        @(negedge clk);
        chk("b2b_done_drop", int'(done), 0);
        chk("b2b_busy_rise", int'(busy), 1);
        wait_done(lat);
        chk("b2b_lat2", lat, 14);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_no_restart", int'(busy), 0);

        // start mid-conversion is ignored
        @(negedge clk);
        bcd_in = 16'h0314;
        start  = 1'b1;
        sb.push_back('{14'd314, 1'b0});
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'h5555;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("held_result", int'(result), 100);
        chk("mid_busy", int'(busy), 1);
        start = 1'b0;
        wait_done(lat);
        @(negedge clk);
        dc = done_cnt;
        repeat (20) @(negedge clk);
        chk("single_done", done_cnt, dc);
        chk("idle_after_ignore", int'(busy), 0);

        // async reset mid-conversion
        @(negedge clk);
        bcd_in = 16'h4321;
        start  = 1'b1;
        sb.push_back('{14'd4321, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_err", int'(err), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dc = done_cnt;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        run_conv(16'h0815, 14'd815, 1'b0);

`ifdef BCD_CHECK_EN
        run_conv(16'h12A4, 14'd0, 1'b1);
        @(negedge clk);
        chk("err_held", int'(err), 1);
        run_conv(16'h0007, 14'd7, 1'b0);
        @(negedge clk);
        chk("err_cleared", int'(err), 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
